// File: rtl/seg7_mux_capture_if.sv
// Bundle of the multiplexed display bus, control inputs and the recovered frame outputs
// shared by the capture block and whatever drives or observes it.
interface seg7_mux_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      ena;
    logic                      clr_err;
    logic [6:0]                seg_in;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic [4*NUM_DIGITS-1:0]   digits_out;
    logic                      frame_strobe;
    logic                      frame_valid;
    logic                      err_pattern;
    logic                      err_select;

    modport master (
        output ena, clr_err, seg_in, dig_sel,
        input  digits_out, frame_strobe, frame_valid, err_pattern, err_select
    );

    modport slave (
        input  ena, clr_err, seg_in, dig_sel,
        output digits_out, frame_strobe, frame_valid, err_pattern, err_select
    );
endinterface

// File: rtl/seg7_mux_capture.sv
// Readback of a multiplexed seven-segment display: debounces each digit slot,
// decodes glyphs back to 4-bit codes and publishes complete frames.
module seg7_mux_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_mux_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN_IDLE,
        RUN_COUNTING,
        RUN_CAPTURED
    } run_state_t;

    localparam logic [7:0]            STABLE   = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    run_state_t                run_state_q, run_state_d;
    logic [7:0]                run_cnt_q, run_cnt_d;
    logic [6:0]                prev_seg_q, prev_seg_d;
    logic [NUM_DIGITS-1:0]     prev_sel_q, prev_sel_d;
    logic                      capture;

    logic [NUM_DIGITS-1:0]     seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0]   partial_q, partial_d;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic                      strobe_q, strobe_d;
    logic                      valid_q, valid_d;
    logic                      err_pat_q, err_pat_d;
    logic                      err_sel_q, err_sel_d;

    logic                      publish;
    logic                      sel_onehot;
    logic                      sel_multi;
    logic                      set_pat;
    logic                      set_sel;
    logic [4:0]                glyph;

    // Returns {illegal, code}; a blank digit reads back as F.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h00:   r = 5'h0F;
            default: r = 5'h1E;
        endcase
        return r;
    endfunction

    // Run tracker: one capture per stable run, fired on the edge the count saturates.
    always_comb begin
        run_state_d = run_state_q;
        run_cnt_d   = run_cnt_q;
        prev_seg_d  = prev_seg_q;
        prev_sel_d  = prev_sel_q;
        capture     = 1'b0;
        if (bus.ena) begin
            if (bus.seg_in == prev_seg_q && bus.dig_sel == prev_sel_q) begin
                if (run_state_q != RUN_CAPTURED) begin
                    run_cnt_d = run_cnt_q + 8'd1;
                    if (run_cnt_d == STABLE) begin
                        run_state_d = RUN_CAPTURED;
                        capture     = 1'b1;
                    end else begin
                        run_state_d = RUN_COUNTING;
                    end
                end
            end else begin
                run_cnt_d   = 8'd1;
                prev_seg_d  = bus.seg_in;
                prev_sel_d  = bus.dig_sel;
                run_state_d = RUN_COUNTING;
            end
        end
    end

    // Frame assembly: a full seen mask is published one edge after it fills.
    always_comb begin
        sel_onehot = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - SEL_ONE)) == '0);
        sel_multi  = (bus.dig_sel != '0) && !sel_onehot;
        glyph      = decode_glyph(bus.seg_in);
        publish    = bus.ena && (seen_q == ALL_SEEN);
        seen_d     = publish ? '0 : seen_q;
        partial_d  = partial_q;
        digits_d   = publish ? partial_q : digits_q;
        strobe_d   = publish;
        valid_d    = valid_q | publish;
        set_pat    = 1'b0;
        set_sel    = 1'b0;
        if (capture) begin
            if (sel_onehot) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (bus.dig_sel[i]) begin
                        partial_d[i*4 +: 4] = glyph[3:0];
                        seen_d[i]           = 1'b1;
                    end
                end
                set_pat = glyph[4];
            end else if (sel_multi) begin
                set_sel = 1'b1;
            end
        end
        // A new error outranks a simultaneous clear.
        err_pat_d = set_pat ? 1'b1 : (bus.clr_err ? 1'b0 : err_pat_q);
        err_sel_d = set_sel ? 1'b1 : (bus.clr_err ? 1'b0 : err_sel_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_state_q <= RUN_IDLE;
            run_cnt_q   <= '0;
            prev_seg_q  <= '0;
            prev_sel_q  <= '0;
            seen_q      <= '0;
            partial_q   <= '0;
            digits_q    <= '0;
            strobe_q    <= 1'b0;
            valid_q     <= 1'b0;
            err_pat_q   <= 1'b0;
            err_sel_q   <= 1'b0;
        end else begin
            run_state_q <= run_state_d;
            run_cnt_q   <= run_cnt_d;
            prev_seg_q  <= prev_seg_d;
            prev_sel_q  <= prev_sel_d;
            seen_q      <= seen_d;
            partial_q   <= partial_d;
            digits_q    <= digits_d;
            strobe_q    <= strobe_d;
            valid_q     <= valid_d;
            err_pat_q   <= err_pat_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign bus.digits_out   = digits_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.frame_valid  = valid_q;
    assign bus.err_pattern  = err_pat_q;
    assign bus.err_select   = err_sel_q;
endmodule

// File: tb/tb_seg7_mux_capture.sv
// Directed bench for seg7_mux_capture: expected frames and their strobe cycles are queued
// by the stimulus and matched by a monitor whenever frame_strobe is seen.
module tb_seg7_mux_capture;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   assert_cnt = 0;
    int   fail_cnt = 0;

    typedef struct {
        logic [15:0] frame;
        int          cycle;
    } exp_t;
    exp_t exp_q[$];

    seg7_mux_capture_if #(.NUM_DIGITS(4)) bus ();

    seg7_mux_capture #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one segment/select pair and lets n edges pass; returns 1 time unit after the last edge.
    task automatic apply_stimulus(input logic [6:0] s, input logic [3:0] d, input int n);
        bus.seg_in  = s;
        bus.dig_sel = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [15:0] f, input int latency);
        exp_t e;
        e.frame = f;
        e.cycle = cyc + latency;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clear(input logic [6:0] s, input logic [3:0] d);
        bus.clr_err = 1'b1;
        apply_stimulus(s, d, 1);
        bus.clr_err = 1'b0;
    endtask

    // Every strobe must match the oldest queued frame, both in content and in cycle.
    always @(negedge clk) begin
        if (bus.frame_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                assert_cnt++;
                fail_cnt++;
                $display("[TB] FAIL unexpected_strobe: got digits %h at cycle %0d, expected no strobe",
                         bus.digits_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("frame_digits", {16'h0, bus.digits_out}, {16'h0, e.frame});
                check_output("strobe_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.clr_err = 1'b0;
        bus.seg_in  = 7'h00;
        bus.dig_sel = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_digits", {16'h0, bus.digits_out}, 32'h0);
        check_output("reset_strobe", {31'h0, bus.frame_strobe}, 32'h0);
        check_output("reset_valid", {31'h0, bus.frame_valid}, 32'h0);
        check_output("reset_err_pattern", {31'h0, bus.err_pattern}, 32'h0);
        check_output("reset_err_select", {31'h0, bus.err_select}, 32'h0);
        rst_n = 1'b1;

        $display("[TB] single digit capture, no frame");
        apply_stimulus(7'h06, 4'b0001, 4);
        apply_stimulus(7'h06, 4'b0001, 10);
        check_output("t1_valid", {31'h0, bus.frame_valid}, 32'h0);

        $display("[TB] full frame 5432");
        apply_stimulus(7'h5B, 4'b0001, 6);
        apply_stimulus(7'h4F, 4'b0010, 6);
        apply_stimulus(7'h66, 4'b0100, 6);
        expect_frame(16'h5432, 5);
        apply_stimulus(7'h6D, 4'b1000, 6);
        check_output("t2_digits", {16'h0, bus.digits_out}, 32'h5432);
        check_output("t2_valid", {31'h0, bus.frame_valid}, 32'h1);

        $display("[TB] short holds and glitches");
        apply_stimulus(7'h07, 4'b0001, 5);
        apply_stimulus(7'h7F, 4'b0010, 5);
        apply_stimulus(7'h6F, 4'b0100, 5);
        apply_stimulus(7'h66, 4'b1000, 3);
        apply_stimulus(7'h6D, 4'b1000, 1);
        apply_stimulus(7'h6F, 4'b0100, 5);
        expect_frame(16'h0987, 5);
        apply_stimulus(7'h3F, 4'b1000, 6);
        check_output("t3_digits", {16'h0, bus.digits_out}, 32'h0987);

        $display("[TB] illegal glyphs and error clear");
        apply_stimulus(7'h49, 4'b0100, 5);
        check_output("t4_err_set", {31'h0, bus.err_pattern}, 32'h1);
        apply_stimulus(7'h77, 4'b0001, 3);
        pulse_clear(7'h77, 4'b0001);
        check_output("t4_err_wins", {31'h0, bus.err_pattern}, 32'h1);
        pulse_clear(7'h77, 4'b0001);
        check_output("t4_err_cleared", {31'h0, bus.err_pattern}, 32'h0);
        apply_stimulus(7'h4F, 4'b0010, 5);
        expect_frame(16'h4E3E, 5);
        apply_stimulus(7'h66, 4'b1000, 6);
        check_output("t4_err_after", {31'h0, bus.err_pattern}, 32'h0);

        $display("[TB] select errors and blanking");
        apply_stimulus(7'h06, 4'b0011, 4);
        check_output("t5_sel_set", {31'h0, bus.err_select}, 32'h1);
        apply_stimulus(7'h00, 4'b0000, 8);
        check_output("t5_sel_hold", {31'h0, bus.err_select}, 32'h1);
        check_output("t5_pat_clean", {31'h0, bus.err_pattern}, 32'h0);
        pulse_clear(7'h00, 4'b0000);
        check_output("t5_sel_cleared", {31'h0, bus.err_select}, 32'h0);
        apply_stimulus(7'h06, 4'b0010, 5);
        apply_stimulus(7'h5B, 4'b0100, 5);
        apply_stimulus(7'h4F, 4'b1000, 5);
        expect_frame(16'h3214, 5);
        apply_stimulus(7'h66, 4'b0001, 6);
        check_output("t5_digits", {16'h0, bus.digits_out}, 32'h3214);

        $display("[TB] mid-frame reset and enable pause");
        apply_stimulus(7'h3F, 4'b0001, 5);
        apply_stimulus(7'h06, 4'b0010, 5);
        apply_stimulus(7'h49, 4'b0100, 5);
        apply_stimulus(7'h06, 4'b0011, 4);
        check_output("t6_pre_err", {30'h0, bus.err_pattern, bus.err_select}, 32'h3);
        rst_n = 1'b0;
        apply_stimulus(7'h06, 4'b0011, 1);
        check_output("t6_rst_digits", {16'h0, bus.digits_out}, 32'h0);
        check_output("t6_rst_flags",
                     {28'h0, bus.frame_strobe, bus.frame_valid, bus.err_pattern, bus.err_select}, 32'h0);
        rst_n = 1'b1;
        apply_stimulus(7'h07, 4'b0100, 5);
        apply_stimulus(7'h00, 4'b1000, 5);
        apply_stimulus(7'h7F, 4'b0010, 5);
        expect_frame(16'hF780, 8);
        apply_stimulus(7'h3F, 4'b0001, 2);
        bus.ena = 1'b0;
        apply_stimulus(7'h3F, 4'b0001, 3);
        bus.ena = 1'b1;
        apply_stimulus(7'h3F, 4'b0001, 6);
        check_output("t6_digits", {16'h0, bus.digits_out}, 32'hF780);
        check_output("t6_valid", {31'h0, bus.frame_valid}, 32'h1);

        apply_stimulus(7'h3F, 4'b0001, 3);
        check_output("pending_frames", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
